// File: rtl/mmu_pkg.sv
// Shared types for the instruction-side MMU.
// Entry layout and byte-order helper used by the queue and the top.
package mmu_pkg;

   localparam int ISIZE = 128;
   localparam int PAW = 56;

   typedef enum logic [1:0] {
      D_IDLE,
      D_RESP,
      D_MISS_REQ,
      D_MISS_WAIT
   } demand_state_t;

   typedef enum logic {
      PF_IDLE,
      PF_WAIT
   } pf_state_t;

   typedef struct packed {
      logic [PAW-1:0]   tag;
      logic [ISIZE-1:0] data;
   } fetch_entry_t;

   function automatic logic [ISIZE-1:0] byteswap(input logic [ISIZE-1:0] d);
      return {<<8{d}};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Tagged circular FIFO holding prefetched cache lines.
// Push and pop may coincide, including when full.
module fetch_queue
   import mmu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fetch_entry_t           entry,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr;
   logic [AW-1:0]  rd;
   logic           do_push;
   logic           do_pop;

   assign valid   = count != '0;
   assign head    = mem[rd];
   assign do_pop  = pop && valid;
   assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr] <= entry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wr <= wr + 1'b1;
         if (do_pop)
            rd <= rd + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/prefetch_immu.sv
// Instruction-side MMU: fetch address check, sequential prefetch
// queue, shared cache port and big-endian bundle formatting.
module prefetch_immu
   import mmu_pkg::*;
#(
   parameter int INSTRUCTIONSIZE = ISIZE,
   parameter int PADDRWIDTH      = PAW,
   parameter int DEPTH           = 4,
   parameter int PAGEBYTES       = 4096,
   parameter bit BIGENDIAN       = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [63:0]                address,
   input  logic                       doFetch,
   output logic [INSTRUCTIONSIZE-1:0] instruction,
   output logic                       doneFetch,
   output logic                       fetchFault,
   output logic [PADDRWIDTH-1:0]      cacheAddress,
   output logic                       cacheReq,
   input  logic                       cacheAck,
   input  logic [INSTRUCTIONSIZE-1:0] cacheData
);

   localparam int BYTES = INSTRUCTIONSIZE / 8;
   localparam int OFFW  = $clog2(BYTES);
   localparam int PGW   = $clog2(PAGEBYTES);
   localparam int CW    = $clog2(DEPTH) + 1;

   demand_state_t           dstate;
   pf_state_t               pstate;
   logic                    d_req;
   logic                    pf_req;
   logic [PADDRWIDTH-1:0]   d_addr;
   logic [PADDRWIDTH-1:0]   pf_addr;
   logic [PADDRWIDTH:0]     pf_ptr;
   logic                    pf_en;
   logic                    pf_drop;
   logic [PADDRWIDTH-1:PGW] last_page;

   fetch_entry_t            q_head;
   fetch_entry_t            q_in;
   logic                    q_valid;
   logic [CW-1:0]           q_count;

   logic sample;
   logic fault;
   logic hit;
   logic flush;
   logic pop;
   logic push;
   logic miss_ack;
   logic same_page;
   logic pf_issue;

   function automatic logic [INSTRUCTIONSIZE-1:0] fmt(
      input logic [INSTRUCTIONSIZE-1:0] d
   );
      return BIGENDIAN ? byteswap(d) : d;
   endfunction

   assign fault = (address[63:PADDRWIDTH] != '0) ||
                  (address[OFFW-1:0] != '0);
   assign hit   = q_valid && (q_head.tag == address[PADDRWIDTH-1:0]);

   assign sample   = (dstate == D_IDLE) && doFetch;
   assign flush    = sample && (fault || !hit);
   assign pop      = sample && !fault && hit;
   assign miss_ack = (dstate == D_MISS_WAIT) && cacheAck;

   // Flush beats a same-cycle prefetch ack: the line is dropped.
   assign push = (pstate == PF_WAIT) && cacheAck && !pf_drop && !flush;
   assign q_in = '{tag: pf_addr, data: cacheData};

   assign same_page = pf_ptr[PADDRWIDTH-1:PGW] == last_page;
   assign pf_issue  = (pstate == PF_IDLE) && pf_en && !flush &&
                      (dstate != D_MISS_REQ) &&
                      (dstate != D_MISS_WAIT) &&
                      (q_count < CW'(DEPTH)) &&
                      !pf_ptr[PADDRWIDTH] && same_page;

   assign cacheReq     = d_req | pf_req;
   assign cacheAddress = pf_req ? pf_addr : d_addr;

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .entry (q_in),
      .pop   (pop),
      .flush (flush),
      .head  (q_head),
      .valid (q_valid),
      .count (q_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dstate      <= D_IDLE;
         d_req       <= 1'b0;
         d_addr      <= '0;
         doneFetch   <= 1'b0;
         fetchFault  <= 1'b0;
         instruction <= '0;
      end else begin
         unique case (dstate)
            D_IDLE: begin
               if (doFetch) begin
                  if (fault) begin
                     doneFetch   <= 1'b1;
                     fetchFault  <= 1'b1;
                     instruction <= '0;
                     dstate      <= D_RESP;
                  end else if (hit) begin
                     doneFetch   <= 1'b1;
                     instruction <= fmt(q_head.data);
                     dstate      <= D_RESP;
                  end else begin
                     dstate <= D_MISS_REQ;
                  end
               end
            end
            D_MISS_REQ: begin
               // Let an in-flight prefetch drain before taking the port.
               if (pstate == PF_IDLE) begin
                  d_req  <= 1'b1;
                  d_addr <= address[PADDRWIDTH-1:0];
                  dstate <= D_MISS_WAIT;
               end
            end
            D_MISS_WAIT: begin
               if (cacheAck) begin
                  d_req       <= 1'b0;
                  doneFetch   <= 1'b1;
                  instruction <= fmt(cacheData);
                  dstate      <= D_RESP;
               end
            end
            D_RESP: begin
               doneFetch  <= 1'b0;
               fetchFault <= 1'b0;
               dstate     <= D_IDLE;
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pstate    <= PF_IDLE;
         pf_req    <= 1'b0;
         pf_addr   <= '0;
         pf_ptr    <= '0;
         pf_en     <= 1'b0;
         pf_drop   <= 1'b0;
         last_page <= '0;
      end else begin
         if (sample && !fault)
            last_page <= address[PADDRWIDTH-1:PGW];
         if (miss_ack) begin
            pf_ptr <= {1'b0, d_addr} + (PADDRWIDTH+1)'(BYTES);
            pf_en  <= 1'b1;
         end else if (flush) begin
            pf_en <= 1'b0;
         end
         unique case (pstate)
            PF_IDLE: begin
               if (pf_issue) begin
                  pf_req  <= 1'b1;
                  pf_addr <= pf_ptr[PADDRWIDTH-1:0];
                  pf_drop <= 1'b0;
                  pstate  <= PF_WAIT;
               end
            end
            PF_WAIT: begin
               if (flush)
                  pf_drop <= 1'b1;
               if (cacheAck) begin
                  pf_req <= 1'b0;
                  pstate <= PF_IDLE;
                  if (push)
                     pf_ptr <= pf_ptr + (PADDRWIDTH+1)'(BYTES);
               end
            end
            default: pstate <= PF_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prefetch_immu.sv
// Scoreboard bench for prefetch_immu with a latency-controlled
// cache responder and a log of acknowledged cache addresses.
module tb_prefetch_immu;

   typedef struct packed {
      logic         f;
      logic [127:0] d;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [63:0]  address;
   logic         doFetch;
   logic [127:0] instruction;
   logic         doneFetch;
   logic         fetchFault;
   logic [55:0]  cacheAddress;
   logic         cacheReq;
   logic         cacheAck;
   logic [127:0] cacheData;

   int           n_cmp = 0;
   int           n_bad = 0;
   exp_t         sb[$];
   exp_t         mon_e;
   logic [55:0]  req_log[$];
   int           cache_lat;
   bit           cache_en;
   int           stray_cnt;
   int           stray_done = 0;
   int           wcnt = 0;
   int           lat;
   int           n;

   prefetch_immu dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .address      (address),
      .doFetch      (doFetch),
      .instruction  (instruction),
      .doneFetch    (doneFetch),
      .fetchFault   (fetchFault),
      .cacheAddress (cacheAddress),
      .cacheReq     (cacheReq),
      .cacheAck     (cacheAck),
      .cacheData    (cacheData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] line(input logic [63:0] a);
      logic [127:0] l;
      int           v;
      for (int i = 0; i < 16; i++) begin
         v = int'(a[11:4]) * 16 + i + (int'(a[19:12]) - 1) * 55;
         l[8*i +: 8] = v[7:0];
      end
      return l;
   endfunction

   function automatic logic [127:0] swap_m(input logic [127:0] l);
      logic [127:0] r;
      for (int j = 0; j < 16; j++)
         r[8*j +: 8] = l[8*(15-j) +: 8];
      return r;
   endfunction

   function automatic logic [55:0] logat(input int i);
      if (i < req_log.size())
         return req_log[i];
      return '1;
   endfunction

   initial begin
      cacheAck  = 1'b0;
      cacheData = '0;
      forever begin
         @(posedge clk);
         #2;
         if (cacheAck) begin
            cacheAck = 1'b0;
            wcnt = 0;
         end else if (stray_done != stray_cnt) begin
            stray_done++;
            cacheAck  = 1'b1;
            cacheData = {4{32'hdeadbeef}};
         end else if (cache_en && cacheReq) begin
            wcnt++;
            if (wcnt >= cache_lat) begin
               cacheAck  = 1'b1;
               cacheData = line({8'h0, cacheAddress});
               req_log.push_back(cacheAddress);
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && doneFetch) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("instruction", instruction, mon_e.d);
            chk("fetchFault", fetchFault, mon_e.f);
         end
      end
   end

   task automatic fetch(input logic [63:0] a, input logic flt,
                        output int l);
      exp_t e;
      e.f = flt;
      e.d = flt ? '0 : swap_m(line(a));
      sb.push_back(e);
      @(posedge clk);
      #1;
      address = a;
      doFetch = 1'b1;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!doneFetch && l < 200);
      if (!doneFetch) begin
         chk("fetch_timeout", 1'b0, 1'b1);
         sb.delete();
      end
      @(posedge clk);
      #1;
      doFetch = 1'b0;
      @(negedge clk);
      chk("done_pulse", doneFetch, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      doFetch   = 1'b0;
      address   = '0;
      cache_en  = 1'b1;
      cache_lat = 3;
      stray_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_done", doneFetch, 1'b0);
      chk("rst_fault", fetchFault, 1'b0);
      chk("rst_req", cacheReq, 1'b0);
      chk("rst_instr", instruction, '0);
      chk("rst_caddr", cacheAddress, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      fetch(64'h1000, 1'b0, lat);
      chk("cold_miss_path", lat > 2, 1'b1);
      repeat (60) @(posedge clk);
      chk("pf_count", req_log.size(), 5);
      for (int i = 0; i < 5; i++)
         chk("pf_addr", logat(i), 56'h1000 + 56'(i * 16));

      req_log.delete();
      fetch(64'h1010, 1'b0, lat);
      chk("hit1010_lat", lat, 2);
      repeat (15) @(posedge clk);
      chk("refill_cnt", req_log.size(), 1);
      chk("refill_addr", logat(0), 56'h1050);
      fetch(64'h1020, 1'b0, lat);
      chk("hit1020_lat", lat, 2);
      repeat (15) @(posedge clk);

      req_log.delete();
      cache_lat = 6;
      fetch(64'h1030, 1'b0, lat);
      chk("hit1030_lat", lat, 2);
      fetch(64'h8000, 1'b0, lat);
      chk("redir_miss", lat > 2, 1'b1);
      chk("redir_inflight", logat(0), 56'h1070);
      chk("redir_demand", logat(1), 56'h8000);
      repeat (60) @(posedge clk);
      chk("redir_pf_cnt", req_log.size(), 6);
      chk("redir_pf_addr", logat(2), 56'h8010);

      req_log.delete();
      cache_lat = 3;
      fetch(64'h1070, 1'b0, lat);
      chk("dropped_miss", lat > 2, 1'b1);
      chk("dropped_addr", logat(0), 56'h1070);
      repeat (40) @(posedge clk);

      req_log.delete();
      fetch(64'h0100_0000_0000_0000, 1'b1, lat);
      chk("fault_hi_lat", lat, 2);
      fetch(64'h1004, 1'b1, lat);
      chk("fault_mis_lat", lat, 2);
      repeat (20) @(posedge clk);
      chk("fault_noreq", req_log.size(), 0);
      fetch(64'h1080, 1'b0, lat);
      chk("fault_flushed", lat > 2, 1'b1);
      repeat (40) @(posedge clk);

      req_log.delete();
      fetch(64'h1FF0, 1'b0, lat);
      chk("page_miss", lat > 2, 1'b1);
      repeat (30) @(posedge clk);
      chk("page_nopf", req_log.size(), 1);
      req_log.delete();
      fetch(64'h2000, 1'b0, lat);
      chk("page_next_miss", lat > 2, 1'b1);
      chk("page_next_addr", logat(0), 56'h2000);
      repeat (40) @(posedge clk);

      cache_en = 1'b0;
      @(posedge clk);
      #1;
      address = 64'h3000;
      doFetch = 1'b1;
      n = 0;
      while (!cacheReq && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mid_req", cacheReq, 1'b1);
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      doFetch = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray_cnt++;
      repeat (3) begin
         @(negedge clk);
         chk("mid_done", doneFetch, 1'b0);
         chk("mid_reqlow", cacheReq, 1'b0);
      end
      chk("mid_fault", fetchFault, 1'b0);
      chk("mid_instr", instruction, '0);
      chk("mid_caddr", cacheAddress, '0);
      cache_en = 1'b1;
      fetch(64'h2010, 1'b0, lat);
      chk("mid_qempty", lat > 2, 1'b1);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
